// File: rtl/multi_digit_seven_segment.sv
// -----------------------------------------------------------------------------
// multi_digit_seven_segment
//
// Time-multiplexed driver for a bank of common-segment seven-segment digits.
// A packed multi-nibble value is latched into a display register and one digit
// is shown at a time. Every digit slot lasts REFRESH_DIV cycles: the first cycle
// of a slot is dark, so the previous digit cannot ghost into the next one. A
// sticky error flag blinks the decimal point with a half-period of BLINK_SCANS
// complete scan frames.
//
// Ports
//   clock        in   system clock, rising edge
//   resetN       in   asynchronous active-low reset
//   load         in   capture binaryNumber into the display register
//   binaryNumber in   packed nibbles, [3:0] is digit 0 (least significant)
//   isError      in   set the sticky error flag (wins over clearError)
//   clearError   in   clear the sticky error flag
//   segments     out  {A,B,C,D,E,F,G}, A at bit 6, physical pin level
//   DP           out  decimal point / error indicator, physical pin level
//   digitEnable  out  one-hot digit enable, physical pin level
//   frameTick    out  one-cycle active-high pulse per complete scan frame
//
// All outputs are registered and are computed from the state held before the
// edge that updates them (one cycle of latency). ACTIVE_LOW inverts segments,
// DP and digitEnable at the register, so reset already drives the inactive
// physical level.
// -----------------------------------------------------------------------------
module multi_digit_seven_segment #(
   parameter int DIGITS        = 4,
   parameter int REFRESH_DIV   = 1000,
   parameter int BLINK_SCANS   = 64,
   parameter int BLANK_LEADING = 0,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   binaryNumber,
   input  logic                  isError,
   input  logic                  clearError,
   output logic [6:0]            segments,
   output logic                  DP,
   output logic [DIGITS-1:0]     digitEnable,
   output logic                  frameTick
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
   localparam int FW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

   localparam logic [PW-1:0]     P_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]     I_LAST = IW'(DIGITS - 1);
   localparam logic [FW-1:0]     F_LAST = FW'(BLINK_SCANS - 1);
   localparam logic              POL    = (ACTIVE_LOW != 0);
   localparam logic [6:0]        SEG_OFF = {7{POL}};
   localparam logic [DIGITS-1:0] EN_OFF  = {DIGITS{POL}};
   localparam logic [DIGITS-1:0] EN_ONE  = {{(DIGITS-1){1'b0}}, 1'b1};

   // State
   logic [4*DIGITS-1:0] r_disp;
   logic                r_err;
   logic [PW-1:0]       r_p;
   logic [IW-1:0]       r_i;
   logic [FW-1:0]       r_frame;
   logic                r_blink;

   // Registered outputs, held at physical pin level
   logic [6:0]          r_seg;
   logic                r_dp;
   logic [DIGITS-1:0]   r_en;
   logic                r_tick;

   // Combinational helpers
   logic                w_p_last;
   logic                w_wrap;
   logic                w_err_next;
   logic                w_err_rise;
   logic                w_on;
   logic [3:0]          w_nibble;
   logic                w_upper_zero;
   logic                w_blank;
   logic [6:0]          w_glyph;
   logic [6:0]          w_seg_log;

   function automatic logic [6:0] f_decode(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'b1111110;
         4'h1: g = 7'b0110000;
         4'h2: g = 7'b1101101;
         4'h3: g = 7'b1111001;
         4'h4: g = 7'b0110011;
         4'h5: g = 7'b1011011;
         4'h6: g = 7'b1011111;
         4'h7: g = 7'b1110000;
         4'h8: g = 7'b1111111;
         4'h9: g = 7'b1111011;
         4'hA: g = 7'b1110111;
         4'hB: g = 7'b0011111;
         4'hC: g = 7'b1001110;
         4'hD: g = 7'b0111101;
         4'hE: g = 7'b1001111;
         default: g = 7'b1000111;
      endcase
      return g;
   endfunction

   assign w_p_last   = (r_p == P_LAST);
   // Index wrap: last cycle of the last digit slot.
   assign w_wrap     = w_p_last && (r_i == I_LAST);
   // Set wins over clear when both arrive on the same edge.
   assign w_err_next = isError | (r_err & ~clearError);
   assign w_err_rise = isError & ~r_err;
   // Slot cycle 0 is the anti-ghosting dark cycle.
   assign w_on       = (r_p != '0);

   // Select the current nibble and find whether it and everything above it
   // is zero (leading-zero blanking; digit 0 is always shown).
   always_comb begin
      w_nibble     = 4'd0;
      w_upper_zero = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (IW'(k) == r_i) begin
            w_nibble = r_disp[4*k +: 4];
         end
         if ((IW'(k) >= r_i) && (r_disp[4*k +: 4] != 4'd0)) begin
            w_upper_zero = 1'b0;
         end
      end
      w_blank = (BLANK_LEADING != 0) && (r_i != '0) && w_upper_zero;
   end

   assign w_glyph   = f_decode(w_nibble);
   assign w_seg_log = (w_on && !w_blank) ? w_glyph : 7'b0000000;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_disp  <= '0;
         r_err   <= 1'b0;
         r_p     <= '0;
         r_i     <= '0;
         r_frame <= '0;
         r_blink <= 1'b0;
         r_seg   <= SEG_OFF;
         r_dp    <= POL;
         r_en    <= EN_OFF;
         r_tick  <= 1'b0;
      end else begin
         if (load) begin
            r_disp <= binaryNumber;
         end
         r_err <= w_err_next;

         // Prescaler and digit index
         if (w_p_last) begin
            r_p <= '0;
            r_i <= (r_i == I_LAST) ? '0 : r_i + 1'b1;
         end else begin
            r_p <= r_p + 1'b1;
         end

         // Blink timing restarts on a fresh error so the first blink is a
         // full lit half-period.
         if (w_err_rise) begin
            r_frame <= '0;
            r_blink <= 1'b1;
         end else if (w_wrap) begin
            if (r_frame == F_LAST) begin
               r_frame <= '0;
               r_blink <= ~r_blink;
            end else begin
               r_frame <= r_frame + 1'b1;
            end
         end

         // Outputs from pre-edge state
         r_seg  <= w_seg_log ^ SEG_OFF;
         r_en   <= (w_on ? (EN_ONE << r_i) : '0) ^ EN_OFF;
         r_dp   <= (w_on & r_err & r_blink) ^ POL;
         r_tick <= w_wrap;
      end
   end

   assign segments    = r_seg;
   assign DP          = r_dp;
   assign digitEnable = r_en;
   assign frameTick   = r_tick;

endmodule

// File: tb/tb_multi_digit_seven_segment.sv
// -----------------------------------------------------------------------------
// tb_multi_digit_seven_segment
//
// Three instances share one stimulus stream:
//   dut_a : base configuration (active-high, no blanking)
//   dut_b : ACTIVE_LOW=1, otherwise identical to dut_a
//   dut_c : BLANK_LEADING=1, otherwise identical to dut_a
// A reference model expresses the scan position as arithmetic on the number of
// edges since reset, and blink phase as the parity of frames since the last
// error onset.
// -----------------------------------------------------------------------------
module tb_multi_digit_seven_segment;

   localparam int D  = 4;
   localparam int R  = 4;
   localparam int BS = 2;

   localparam logic [6:0] GLYPH [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic resetN = 1'b1;
   always #5 clock = ~clock;

   logic          load = 1'b0;
   logic [15:0]   binaryNumber = '0;
   logic          isError = 1'b0;
   logic          clearError = 1'b0;

   logic [6:0] a_seg, b_seg, c_seg;
   logic       a_dp, b_dp, c_dp;
   logic [3:0] a_en, b_en, c_en;
   logic       a_tick, b_tick, c_tick;

   multi_digit_seven_segment #(.DIGITS(D), .REFRESH_DIV(R), .BLINK_SCANS(BS),
      .BLANK_LEADING(0), .ACTIVE_LOW(0)) dut_a (
      .clock(clock), .resetN(resetN), .load(load), .binaryNumber(binaryNumber),
      .isError(isError), .clearError(clearError), .segments(a_seg), .DP(a_dp),
      .digitEnable(a_en), .frameTick(a_tick));

   multi_digit_seven_segment #(.DIGITS(D), .REFRESH_DIV(R), .BLINK_SCANS(BS),
      .BLANK_LEADING(0), .ACTIVE_LOW(1)) dut_b (
      .clock(clock), .resetN(resetN), .load(load), .binaryNumber(binaryNumber),
      .isError(isError), .clearError(clearError), .segments(b_seg), .DP(b_dp),
      .digitEnable(b_en), .frameTick(b_tick));

   multi_digit_seven_segment #(.DIGITS(D), .REFRESH_DIV(R), .BLINK_SCANS(BS),
      .BLANK_LEADING(1), .ACTIVE_LOW(0)) dut_c (
      .clock(clock), .resetN(resetN), .load(load), .binaryNumber(binaryNumber),
      .isError(isError), .clearError(clearError), .segments(c_seg), .DP(c_dp),
      .digitEnable(c_en), .frameTick(c_tick));

   // Logical view of the active-low instance
   logic [6:0] b_seg_n;
   logic [3:0] b_en_n;
   logic       b_dp_n;
   assign b_seg_n = ~b_seg;
   assign b_en_n  = ~b_en;
   assign b_dp_n  = ~b_dp;

   // ---------------- scoreboard counters / check ----------------
   int tests  = 0;
   int failed = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_n;       // edges since reset release
   logic [15:0] m_disp;
   logic        m_err;
   logic        m_base;    // blink phase at the last onset point
   int          m_wraps;   // frames completed since that point

   logic [3:0]  e_en;
   logic [6:0]  e_seg;
   logic [6:0]  e_seg_bl;
   logic        e_dp;
   logic        e_tick;

   function automatic logic [3:0] f_en(input int n);
      int s = n % R;
      int d = (n / R) % D;
      logic [3:0] one = 4'd1;
      return (s != 0) ? (one << d) : 4'd0;
   endfunction

   function automatic logic [6:0] f_seg(input int n, input logic [15:0] v, input bit bl);
      int s = n % R;
      int d = (n / R) % D;
      logic [15:0] sh = v >> (4 * d);
      logic [3:0]  nib = sh[3:0];
      if (s == 0) return 7'd0;
      if (bl && d > 0 && sh == 16'd0) return 7'd0;
      return GLYPH[nib];
   endfunction

   function automatic logic f_tick(input int n);
      return (n % (R * D)) == (R * D - 1);
   endfunction

   always @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         m_n      <= 0;
         m_disp   <= '0;
         m_err    <= 1'b0;
         m_base   <= 1'b0;
         m_wraps  <= 0;
         e_en     <= '0;
         e_seg    <= '0;
         e_seg_bl <= '0;
         e_dp     <= 1'b0;
         e_tick   <= 1'b0;
      end else begin
         e_en     <= f_en(m_n);
         e_seg    <= f_seg(m_n, m_disp, 1'b0);
         e_seg_bl <= f_seg(m_n, m_disp, 1'b1);
         e_dp     <= (f_en(m_n) != 0) && m_err && (m_base ^ ((m_wraps / BS) % 2 == 1));
         e_tick   <= f_tick(m_n);
         m_n      <= m_n + 1;
         if (load) m_disp <= binaryNumber;
         m_err    <= isError ? 1'b1 : (clearError ? 1'b0 : m_err);
         if (isError && !m_err) begin
            m_wraps <= 0;
            m_base  <= 1'b1;
         end else if (f_tick(m_n)) begin
            m_wraps <= m_wraps + 1;
         end
      end
   end

   // Continuous comparison on the falling edge
   bit chk_on = 1'b0;
   always @(negedge clock) begin
      if (resetN && chk_on) begin
         chk("a_en", 32'(a_en), 32'(e_en));
         chk("a_dp", 32'(a_dp), 32'(e_dp));
         chk("a_tick", 32'(a_tick), 32'(e_tick));
         if (e_en != 0) chk("a_seg", 32'(a_seg), 32'(e_seg));
         chk("b_en", 32'(b_en_n), 32'(e_en));
         chk("b_dp", 32'(b_dp_n), 32'(e_dp));
         chk("b_tick", 32'(b_tick), 32'(e_tick));
         if (e_en != 0) chk("b_seg", 32'(b_seg_n), 32'(e_seg));
         chk("c_en", 32'(c_en), 32'(e_en));
         chk("c_dp", 32'(c_dp), 32'(e_dp));
         if (e_en != 0) chk("c_seg", 32'(c_seg), 32'(e_seg_bl));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_slot();
      @(negedge clock);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v);
      drive_slot();
      binaryNumber = v;
      load = 1'b1;
      drive_slot();
      load = 1'b0;
   endtask

   task automatic pulse_err(input logic set_e, input logic clr_e);
      drive_slot();
      isError = set_e;
      clearError = clr_e;
      drive_slot();
      isError = 1'b0;
      clearError = 1'b0;
   endtask

   // Returns at a falling edge where dut_a enables digit d.
   task automatic wait_digit(input int d);
      bit found = 1'b0;
      logic [3:0] want = 4'd1;
      want = want << d;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clock);
         if (a_en == want) found = 1'b1;
      end
      if (!found) chk("wait_digit_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_any();
      bit found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clock);
         if (a_en != 0) found = 1'b1;
      end
      if (!found) chk("wait_any_timeout", 32'd0, 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int ticks;
      // Asynchronous reset, checked with no clock edge in between
      #1 resetN = 1'b0;
      #1;
      chk("rst_a_seg", 32'(a_seg), 32'h00);
      chk("rst_a_dp", 32'(a_dp), 32'h0);
      chk("rst_a_en", 32'(a_en), 32'h0);
      chk("rst_a_tick", 32'(a_tick), 32'h0);
      chk("rst_b_seg", 32'(b_seg), 32'h7f);
      chk("rst_b_dp", 32'(b_dp), 32'h1);
      chk("rst_b_en", 32'(b_en), 32'hf);
      chk("rst_b_tick", 32'(b_tick), 32'h0);
      repeat (2) @(negedge clock);
      #1 resetN = 1'b1;
      chk_on = 1'b1;

      @(negedge clock);
      chk("edge1_dark", 32'(a_en), 32'h0);
      @(negedge clock);
      chk("edge2_dig0", 32'(a_en), 32'h1);
      chk("edge2_zero", 32'(a_seg), 32'(7'b1111110));

      // Decode
      do_load(16'h3210); wait_digit(0); chk("glyph_0", 32'(a_seg), 32'(7'b1111110));
      do_load(16'h7654); wait_digit(0); chk("glyph_4", 32'(a_seg), 32'(7'b0110011));
      do_load(16'hBA98); wait_digit(3); chk("glyph_b", 32'(a_seg), 32'(7'b0011111));
      do_load(16'hFEDC); wait_digit(3); chk("glyph_F", 32'(a_seg), 32'(7'b1000111));

      // Frame tick rate: a 64-cycle window holds exactly 4 pulses
      ticks = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clock);
         if (a_tick) ticks++;
      end
      chk("tick_count", 32'(ticks), 32'd4);

      // Error flag
      pulse_err(1'b1, 1'b0); wait_any(); chk("err_dp_on", 32'(a_dp), 32'h1);
      pulse_err(1'b0, 1'b1); @(negedge clock); chk("clr_dp_off", 32'(a_dp), 32'h0);
      pulse_err(1'b1, 1'b1); wait_any(); chk("both_from_clear", 32'(a_dp), 32'h1);
      pulse_err(1'b1, 1'b1); wait_any(); chk("both_keep_set", 32'(a_dp), 32'h1);
      repeat (80) @(negedge clock);      // blink toggling observed by the model
      pulse_err(1'b0, 1'b1);

      // Blanking
      do_load(16'h0050);
      wait_digit(3); chk("bl50_d3", 32'(c_seg), 32'h00);
      wait_digit(2); chk("bl50_d2", 32'(c_seg), 32'h00);
      wait_digit(1); chk("bl50_d1", 32'(c_seg), 32'(7'b1011011));
      wait_digit(0); chk("bl50_d0", 32'(c_seg), 32'(7'b1111110));
      do_load(16'h0000);
      wait_digit(1); chk("bl0_d1", 32'(c_seg), 32'h00);
      wait_digit(0); chk("bl0_d0", 32'(c_seg), 32'(7'b1111110));
      do_load(16'h1000);
      wait_digit(2); chk("bl1000_d2", 32'(c_seg), 32'(7'b1111110));
      wait_digit(3); chk("bl1000_d3", 32'(c_seg), 32'(7'b0110000));

      // Randomized traffic, including loads mid-slot and leading zeros
      for (int k = 0; k < 2500; k++) begin
         drive_slot();
         load = ($urandom_range(0, 7) == 0);
         binaryNumber = 16'($urandom) >> (4 * $urandom_range(0, 4));
         isError = ($urandom_range(0, 59) == 0);
         clearError = ($urandom_range(0, 59) == 0);
      end
      drive_slot();
      load = 1'b0; isError = 1'b0; clearError = 1'b0;

      // Reset during digit 2 with the error flag set
      do_load(16'h4321);
      pulse_err(1'b1, 1'b0);
      wait_digit(2);
      #1 resetN = 1'b0;
      #1;
      chk("mid_rst_a_en", 32'(a_en), 32'h0);
      chk("mid_rst_a_seg", 32'(a_seg), 32'h00);
      chk("mid_rst_a_dp", 32'(a_dp), 32'h0);
      chk("mid_rst_b_en", 32'(b_en), 32'hf);
      chk("mid_rst_b_dp", 32'(b_dp), 32'h1);
      repeat (2) @(negedge clock);
      #1 resetN = 1'b1;
      @(negedge clock);
      chk("mid_rel_dark", 32'(a_en), 32'h0);
      @(negedge clock);
      chk("mid_rel_dig0", 32'(a_en), 32'h1);
      chk("mid_rel_zero", 32'(a_seg), 32'(7'b1111110));
      chk("mid_rel_err_clr", 32'(a_dp), 32'h0);
      repeat (40) @(negedge clock);
      chk("mid_rel_err_stays_clr", 32'(a_dp), 32'h0);

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   // Hard time limit
   initial begin
      #2000000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/multi_digit_seven_segment.md
# multi_digit_seven_segment

Parametrised, time-multiplexed driver for a bank of common-segment seven-segment digits with per-frame error blinking. It latches a packed multi-nibble value and scans one digit at a time at a programmable refresh rate. Each digit is decoded to a full hex glyph set, with optional leading-zero blanking and a one-cycle anti-ghosting dark slot between digits. It sits between the vending-machine datapath (credit/price/error) and the board's display pins.

## Interface
- `DIGITS`, 4, number of digits scanned; legal range 1..8.
- `REFRESH_DIV`, 1000, clock cycles per digit slot; legal minimum 2.
- `BLINK_SCANS`, 64, full scan frames per blink half-period; legal minimum 1.
- `BLANK_LEADING`, 0, 1 = blank zero digits above the most significant non-zero digit.
- `ACTIVE_LOW`, 0, 1 = `segments`, `DP` and `digitEnable` are driven inverted at the pins.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `load`  in  1  capture `binaryNumber` into the display register on this edge.
- `binaryNumber`  in  4*DIGITS  packed nibbles; [3:0] is digit 0, the least significant.
- `isError`  in  1  sets the sticky error flag.
- `clearError`  in  1  clears the sticky error flag.
- `segments`  out  7  {A,B,C,D,E,F,G}, A at bit 6; logical 1 = lit.
- `DP`  out  1  decimal point, used as the error indicator.
- `digitEnable`  out  DIGITS  one-hot enable for the digit currently shown.
- `frameTick`  out  1  one-cycle pulse once per complete scan frame.

## Operation
- Display register: loads `binaryNumber` on any edge with `load`=1; otherwise holds. A load does not disturb the scan position.
- Error flag: set by `isError`, cleared by `clearError`. When both are high on the same edge, set wins.
- Prescaler `p` counts 0..REFRESH_DIV-1. At its terminal count, digit index `i` advances 0..DIGITS-1 and wraps to 0.
- Frame counter counts index wraps 0..BLINK_SCANS-1. At its terminal count, `blinkPhase` toggles.
  - A 0->1 transition of the error flag clears the frame counter and forces `blinkPhase`=1.
- Decode covers the full hex set, standard glyphs (logical, A..G):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Leading-zero blanking (BLANK_LEADING=1): digit k is blanked (segments 0000000) when every nibble at index >= k is zero. Digit 0 is never blanked.
- Digit selection: `digitEnable[i]` is active while `p` != 0. The slot where `p`==0 is dark (all enables inactive).
- `DP` = error flag AND `blinkPhase`, gated by the same enable as the digit.
- Output polarity: ACTIVE_LOW inverts `segments`, `DP` and `digitEnable` only; `frameTick` is always active-high.

## Timing
- All outputs are registered. Each output is computed from the state and display register at the previous edge, giving 1 cycle of latency.
  - `load` at edge t: the new glyph is visible from edge t+1 whenever the digit is enabled.
  - `isError` at edge t: the flag is set at t. `DP` goes active at t+1 if a digit is enabled at t+1.
  - `clearError` at edge t: `DP` goes inactive at t+1.
- Reset, asynchronous and immediate:
  - Display register, error flag, `p`, `i`, frame counter and `blinkPhase` are all cleared to 0.
  - Outputs go inactive: segments off, DP off, no digit enabled, `frameTick`=0, at their ACTIVE_LOW-adjusted physical levels.
- After `resetN` is released, the first edge sets `p` to 1 and `digitEnable` stays inactive. The second edge enables digit 0.
- Each digit is lit for REFRESH_DIV-1 cycles followed by 1 dark cycle. Frame period is DIGITS*REFRESH_DIV cycles.
- `frameTick` is high for exactly 1 cycle, the cycle after `i` wraps DIGITS-1 -> 0. With DIGITS=1 it pulses every REFRESH_DIV cycles.
- Blink half-period is BLINK_SCANS frames.
- Reset asserted mid-frame aborts the scan. Scanning restarts at digit 0 with p=0.

## Test plan
- Reset/scan (DIGITS=4, REFRESH_DIV=4) -> while `resetN`=0: segments=0000000, DP=0, digitEnable=0000, frameTick=0 with no clock edge required. After release: 0001 from edge 2 for 3 cycles, 1 dark cycle, then 0010, 0100, 1000. `frameTick` pulses every 16 cycles.
- Decode: load 0x3210, 0x7654, 0xBA98, 0xFEDC -> each enabled digit shows the table glyph. Checks include 0=1111110, 4=0110011, b=0011111, F=1000111. A load mid-slot changes the glyph on the next edge without moving the scan.
- Error blink (BLINK_SCANS=2):
  - 1-cycle `isError` -> DP=1 on enabled digits from the next cycle, toggling every 32 cycles.
  - `clearError` -> DP=0 on the next cycle.
  - `isError` and `clearError` together -> flag stays set.
- Blanking (BLANK_LEADING=1):
  - load 0x0050 -> digits 3 and 2 show 0000000, digit 1 shows 1011011, digit 0 shows 1111110.
  - load 0x0000 -> only digit 0 is lit, showing 0.
  - load 0x1000 -> all four digits are lit.
- ACTIVE_LOW=1 -> every reset and steady-state level of `segments`, `DP` and `digitEnable` is the bitwise inverse of the ACTIVE_LOW=0 run. `frameTick` is unchanged.
- `resetN` pulsed low during digit 2 with error set -> outputs go inactive immediately and the error flag is cleared. Digit 0 is enabled on the second edge after release, showing 0.
